// File: rtl/fp_force_accum_ctrl.sv
// Per-particle fp32 force accumulation controller: issues (sum, value) pairs to an
// external pipelined adder with RAW-hazard stalls, writes results back, drains all sums.
module fp_force_accum_ctrl #(
    parameter int unsigned ID_W    = 3,
    parameter int unsigned ADD_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [31:0]     in_value,
    input  logic            drain_req,
    output logic            add_valid,
    output logic [31:0]     add_a,
    output logic [31:0]     add_b,
    input  logic [31:0]     add_result,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [31:0]     out_value,
    output logic            busy
);

    localparam int unsigned     DEPTH    = 1 << ID_W;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        bank   [DEPTH];
    logic [ADD_LAT-1:0] trk_v;
    logic [ID_W-1:0]    trk_id [ADD_LAT];
    logic               drain_pend;
    logic               run;
    logic [ID_W-1:0]    idx;
    logic               hazard;
    logic               accept;
    logic               emit;
    logic               trk_empty;

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        hazard    = 1'b0;
        for (int unsigned i = 0; i < ADD_LAT; i++) begin
            if (trk_v[i] && (trk_id[i] == in_id)) begin
                hazard = 1'b1;
            end
        end
        trk_empty = ~|trk_v;
        in_ready  = run && (state == ACCUM) && !drain_pend && !hazard;
        accept    = in_valid && in_ready;
        busy      = (state != ACCUM) || drain_pend;

        // Index 0 is emitted on the FLUSH->DRAIN edge, so DRAIN covers 1..DEPTH-1.
        case (state)
            ACCUM: begin
                if (drain_req || drain_pend) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (trk_empty) begin
                    emit      = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                emit = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ACCUM;
            run        <= 1'b0;
            drain_pend <= 1'b0;
            idx        <= '0;
            trk_v      <= '0;
            for (int unsigned i = 0; i < ADD_LAT; i++) begin
                trk_id[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            add_valid  <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_value  <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;

            // The add_a/add_b register is the adder's first stage; the tracker's last
            // stage lines up with add_result.
            trk_v[0]  <= accept;
            trk_id[0] <= in_id;
            for (int unsigned i = 1; i < ADD_LAT; i++) begin
                trk_v[i]  <= trk_v[i-1];
                trk_id[i] <= trk_id[i-1];
            end
            if (trk_v[ADD_LAT-1]) begin
                bank[trk_id[ADD_LAT-1]] <= add_result;
            end

            add_valid <= accept;
            if (accept) begin
                add_a <= bank[in_id];
                add_b <= in_value;
            end

            out_valid <= emit;
            if (emit) begin
                out_id    <= idx;
                out_value <= bank[idx];
                bank[idx] <= '0;
                idx       <= idx + 1'b1;
            end

            if ((state == ACCUM) && drain_req && accept) begin
                drain_pend <= 1'b1;
            end else if ((state == DRAIN) && (idx == LAST_IDX)) begin
                drain_pend <= 1'b0;
            end
        end
    end

endmodule
